// File: rtl/mix_grad_ctrl_if.sv
// Handshake bundle between the mix-layer gradient sequencer and its
// datapath / gradient RAM clear port.
`ifndef MIX_GRAD_DEFS
`define MIX_GRAD_DEFS
`define STATE_LEN 2
`define B_MIX1 2'd1
`define B_MIX2 2'd2
`define B_MIX3 2'd3
`define HID_DIM 16
`define DATA_N 4
`endif

interface mix_grad_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int BATCH_W    = 4
);
    logic                  start;
    logic                  clear_req;
    logic [BATCH_W-1:0]    batch_size;
    logic                  grad_valid;
    logic                  grad_run;
    logic [`STATE_LEN-1:0] grad_state;
    logic                  busy;
    logic                  done;
    logic                  batch_done;
    logic                  clr_we_w;
    logic                  clr_we_b;
    logic [ADDR_WIDTH-1:0] clr_waddr_w;
    logic [ADDR_WIDTH-1:0] clr_waddr_b;

    modport master (
        output start, clear_req, batch_size, grad_valid,
        input  grad_run, grad_state, busy, done, batch_done,
        input  clr_we_w, clr_we_b, clr_waddr_w, clr_waddr_b
    );

    modport slave (
        input  start, clear_req, batch_size, grad_valid,
        output grad_run, grad_state, busy, done, batch_done,
        output clr_we_w, clr_we_b, clr_waddr_w, clr_waddr_b
    );
endinterface

// File: rtl/mix_grad_ctrl.sv
// Backward-pass sequencer for the three mix layers: steps the datapath
// through MIX3->MIX2->MIX1, counts batch samples and zeroes the gradient RAM.
`ifndef MIX_GRAD_DEFS
`define MIX_GRAD_DEFS
`define STATE_LEN 2
`define B_MIX1 2'd1
`define B_MIX2 2'd2
`define B_MIX3 2'd3
`define HID_DIM 16
`define DATA_N 4
`endif

module mix_grad_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int BATCH_W    = 4
) (
    input logic       clk,
    input logic       rst_n,
    mix_grad_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    localparam int W_N = 3 * `HID_DIM * `HID_DIM / `DATA_N;
    localparam int B_N = 3 * `HID_DIM;
    localparam int C_N = (W_N > B_N) ? W_N : B_N;

    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(W_N - 1);
    localparam logic [ADDR_WIDTH-1:0] B_LAST = ADDR_WIDTH'(B_N - 1);
    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(C_N - 1);

    logic [2:0]            state_q, state_d;
    logic [`STATE_LEN-1:0] gs_q, gs_d;
    logic [BATCH_W-1:0]    scnt_q, scnt_d;
    logic [BATCH_W-1:0]    scnt_inc, eff_bs;
    logic [ADDR_WIDTH-1:0] ccnt_q, ccnt_d;
    logic                  bdone_d;
    logic                  run_q, busy_q, done_q, bdone_q;
    logic                  we_w_q, we_w_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] aw_q, aw_d, ab_q, ab_d;

    assign eff_bs   = (bus.batch_size == '0) ? BATCH_W'(1) : bus.batch_size;
    assign scnt_inc = scnt_q + BATCH_W'(1);

    always_comb begin
        state_d = state_q;
        gs_d    = gs_q;
        scnt_d  = scnt_q;
        ccnt_d  = ccnt_q;
        bdone_d = 1'b0;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                gs_d = `B_MIX3;
                // clear has priority; a simultaneous start is dropped
                if (bus.clear_req) begin
                    state_d = S_CLEAR;
                    ccnt_d  = '0;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            (state_q == S_RUN): begin
                if (bus.grad_valid) begin
                    case (gs_q)
                        `B_MIX3: begin
                            state_d = S_GAP;
                            gs_d    = `B_MIX2;
                        end
                        `B_MIX2: begin
                            state_d = S_GAP;
                            gs_d    = `B_MIX1;
                        end
                        default: begin
                            state_d = S_DONE;
                            gs_d    = `B_MIX3;
                            if (scnt_inc == eff_bs) begin
                                bdone_d = 1'b1;
                                scnt_d  = '0;
                            end else begin
                                scnt_d = scnt_inc;
                            end
                        end
                    endcase
                end
            end
            (state_q == S_GAP): state_d = S_RUN;
            (state_q == S_DONE): state_d = S_IDLE;
            (state_q == S_CLEAR): begin
                ccnt_d = ccnt_q + ADDR_WIDTH'(1);
                scnt_d = '0;
                if (ccnt_q == C_LAST) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gs_d    = `B_MIX3;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_comb begin
        we_w_d = (state_d == S_CLEAR) && (ccnt_d <= W_LAST);
        we_b_d = (state_d == S_CLEAR) && (ccnt_d <= B_LAST);
        aw_d   = we_w_d ? ccnt_d : '0;
        ab_d   = we_b_d ? ccnt_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gs_q    <= `B_MIX3;
            scnt_q  <= '0;
            ccnt_q  <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bdone_q <= 1'b0;
            we_w_q  <= 1'b0;
            we_b_q  <= 1'b0;
            aw_q    <= '0;
            ab_q    <= '0;
        end else begin
            state_q <= state_d;
            gs_q    <= gs_d;
            scnt_q  <= scnt_d;
            ccnt_q  <= ccnt_d;
            run_q   <= (state_d == S_RUN);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            bdone_q <= bdone_d;
            we_w_q  <= we_w_d;
            we_b_q  <= we_b_d;
            aw_q    <= aw_d;
            ab_q    <= ab_d;
        end
    end

    assign bus.grad_run    = run_q;
    assign bus.grad_state  = gs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.batch_done  = bdone_q;
    assign bus.clr_we_w    = we_w_q;
    assign bus.clr_we_b    = we_b_q;
    assign bus.clr_waddr_w = aw_q;
    assign bus.clr_waddr_b = ab_q;
endmodule
